// File: rtl/sd2_pkg.sv
// ============================================================================
//  Module      : sd2_pkg
//  Description : Shared state encoding, default sizes and counter-width helper
//                for the sd2 sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sd2_pkg;

    localparam int c_BW_DEFAULT       = 32;
    localparam int c_OSR_DEFAULT      = 64;
    localparam int c_WORD_W_DEFAULT   = 32;
    localparam int c_OVLD_LEN_DEFAULT = 24;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STARVE = 2'd2
    } sd2_state_e;

    // Width of a counter that spans 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sd2_bit_packer.sv
// ============================================================================
//  Module      : sd2_bit_packer
//  Description : Packs the modulator bitstream MSB-first into words and
//                presents them on a valid/ready port, flagging dropped words.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sd2_bit_packer
    import sd2_pkg::*;
#(
    parameter int WORD_W = c_WORD_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_capture,
    input  logic              i_flush,
    input  logic              i_bs,
    input  logic              i_out_ready,
    output logic [WORD_W-1:0] o_out_data,
    output logic              o_out_valid,
    output logic              o_drop
);

    localparam int CNT_W = cnt_w(WORD_W);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic [WORD_W-2:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic [WORD_W-1:0] w_word;
    logic              w_done;

    assign w_word = {shift_q, i_bs};
    assign w_done = i_capture && (cnt_q == c_CNT_LAST);
    // A finished word is lost only if the previous one is still unclaimed.
    assign o_drop = w_done & valid_q & ~i_out_ready;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (i_flush) begin
            cnt_d = '0;
        end else if (i_capture) begin
            shift_d = w_word[WORD_W-2:0];
            cnt_d   = w_done ? '0 : cnt_q + c_CNT_ONE;
        end
        if (valid_q && i_out_ready) begin
            valid_d = 1'b0;
        end
        if (w_done && (!valid_q || i_out_ready)) begin
            data_d  = w_word;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign o_out_data  = data_q;
    assign o_out_valid = valid_q;

endmodule

`default_nettype wire

// File: rtl/sd2_ctrl.sv
// ============================================================================
//  Module      : sd2_ctrl
//  Description : Sigma-delta sequencer: zero-order-hold of PCM samples for OSR
//                clocks, bitstream packing and sticky status. Overload
//                detection is built only when SD2_CTRL_OVLD_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sd2_ctrl
    import sd2_pkg::*;
#(
    parameter int BW       = c_BW_DEFAULT,
    parameter int OSR      = c_OSR_DEFAULT,
    parameter int WORD_W   = c_WORD_W_DEFAULT,
    parameter int OVLD_LEN = c_OVLD_LEN_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic [BW-1:0]     in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [BW-1:0]     sd_out,
    input  logic              bs_in,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              underrun,
    output logic              overflow,
    output logic              ovld
);

    localparam int PH_W = cnt_w(OSR);
    localparam logic [PH_W-1:0] c_PH_LAST = PH_W'(OSR - 1);
    localparam logic [PH_W-1:0] c_PH_ONE  = PH_W'(1);

    sd2_state_e      state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [BW-1:0]   sd_out_q, sd_out_d;
    logic            underrun_q, underrun_d;
    logic            overflow_q, overflow_d;
    logic            w_run, w_boundary, w_accept, w_capture, w_flush;
    logic            w_drop, w_underrun_set;

    assign w_run      = (state_q != IDLE);
    assign w_boundary = (state_q == IDLE) || (phase_q == c_PH_LAST);
    assign in_ready   = rst_n & en & w_boundary;
    assign w_accept   = in_ready & in_valid;
    assign w_capture  = en & w_run;
    assign w_flush    = ~en;

    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        sd_out_d       = sd_out_q;
        w_underrun_set = 1'b0;
        if (!en) begin
            state_d  = IDLE;
            phase_d  = '0;
            sd_out_d = '0;
        end else begin
            if (w_run) begin
                phase_d = (phase_q == c_PH_LAST) ? '0 : phase_q + c_PH_ONE;
            end
            if (w_accept) begin
                state_d  = RUN;
                sd_out_d = in_data;
            end else if (w_run && w_boundary) begin
                // Starved frames still last OSR clocks, driving mid-scale.
                state_d        = STARVE;
                sd_out_d       = '0;
                w_underrun_set = 1'b1;
            end
        end
        underrun_d = w_underrun_set | (underrun_q & ~clr);
        overflow_d = w_drop | (overflow_q & ~clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            sd_out_q   <= '0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            sd_out_q   <= sd_out_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
        end
    end

    sd2_bit_packer #(
        .WORD_W (WORD_W)
    ) u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_capture   (w_capture),
        .i_flush     (w_flush),
        .i_bs        (bs_in),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_out_valid (out_valid),
        .o_drop      (w_drop)
    );

`ifdef SD2_CTRL_OVLD_EN
    localparam int RUN_W = cnt_w(OVLD_LEN + 1);
    localparam logic [RUN_W-1:0] c_RUN_MAX = RUN_W'(OVLD_LEN);
    localparam logic [RUN_W-1:0] c_RUN_ONE = RUN_W'(1);

    logic [RUN_W-1:0] run_q, run_d;
    logic             last_q, last_d;
    logic             ovld_q, ovld_d;
    logic             w_ovld_set;

    always_comb begin
        run_d      = run_q;
        last_d     = last_q;
        w_ovld_set = 1'b0;
        if (!en) begin
            run_d = '0;
        end else if (w_capture) begin
            last_d = bs_in;
            if ((run_q == '0) || (bs_in != last_q)) begin
                run_d = c_RUN_ONE;
            end else if (run_q != c_RUN_MAX) begin
                run_d = run_q + c_RUN_ONE;
            end
            w_ovld_set = (run_d == c_RUN_MAX);
        end
        ovld_d = w_ovld_set | (ovld_q & ~clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= '0;
            last_q <= 1'b0;
            ovld_q <= 1'b0;
        end else begin
            run_q  <= run_d;
            last_q <= last_d;
            ovld_q <= ovld_d;
        end
    end

    assign ovld = ovld_q;
`else
    assign ovld = 1'b0;
`endif

    assign sd_out   = sd_out_q;
    assign underrun = underrun_q;
    assign overflow = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_sd2_ctrl.sv
// ============================================================================
//  Module      : tb_sd2_ctrl
//  Description : Self-checking bench for sd2_ctrl (OSR=4, WORD_W=8): directed
//                vector table, hand sequences and a randomized model run.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sd2_ctrl;

    localparam int BW       = 16;
    localparam int OSR      = 4;
    localparam int WW       = 8;
    localparam int OVLD_LEN = 24;
`ifdef SD2_CTRL_OVLD_EN
    localparam logic c_OVL_EXP = 1'b1;
`else
    localparam logic c_OVL_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          clr = 1'b0;
    logic [BW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          bs_in = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic [BW-1:0] sd_out;
    logic [WW-1:0] out_data;
    logic          out_valid;
    logic          underrun;
    logic          overflow;
    logic          ovld;

    int n_cmp = 0;
    int n_err = 0;

    sd2_ctrl #(
        .BW       (BW),
        .OSR      (OSR),
        .WORD_W   (WW),
        .OVLD_LEN (OVLD_LEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .clr       (clr),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sd_out    (sd_out),
        .bs_in     (bs_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .underrun  (underrun),
        .overflow  (overflow),
        .ovld      (ovld)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, want %0h", nm, $time, act, exp);
        end
    endfunction

    // Reference model: frame position, held sample, queue of captured bits.
    logic [BW-1:0] m_sd;
    bit            m_act;
    int            m_pos;
    bit            q_bits[$];
    logic [WW-1:0] m_od;
    bit            m_ov, m_unr, m_ovf, m_ovld;
    int            m_run;
    bit            m_last;

    function automatic void model_reset();
        m_sd = '0; m_act = 0; m_pos = 0; q_bits.delete();
        m_od = '0; m_ov = 0; m_unr = 0; m_ovf = 0; m_ovld = 0;
        m_run = 0; m_last = 0;
    endfunction

    function automatic bit m_rdy();
        return rst_n && en && (!m_act || m_pos == OSR - 1);
    endfunction

    function automatic void model_edge();
        bit rdy, at_end, was_act, unr_set, ovf_set, ovl_set;
        logic [WW-1:0] w;
        rdy     = m_rdy();
        at_end  = m_act && (m_pos == OSR - 1);
        was_act = m_act;
        unr_set = 0; ovf_set = 0; ovl_set = 0;
        if (m_ov && out_ready) m_ov = 0;
        if (!en) begin
            m_act = 0; m_pos = 0; m_sd = '0; q_bits.delete(); m_run = 0;
        end else begin
            if (was_act) begin
                q_bits.push_back(bs_in);
                if (m_run > 0 && bs_in == m_last)
                    m_run = (m_run < OVLD_LEN) ? m_run + 1 : m_run;
                else
                    m_run = 1;
                m_last = bs_in;
                if (m_run >= OVLD_LEN) ovl_set = 1;
                m_pos = (m_pos + 1) % OSR;
            end
            if (q_bits.size() == WW) begin
                w = '0;
                foreach (q_bits[i]) w = {w[WW-2:0], q_bits[i]};
                q_bits.delete();
                if (m_ov) ovf_set = 1;
                else begin m_od = w; m_ov = 1; end
            end
            if (rdy && in_valid) begin
                m_sd = in_data; m_act = 1;
            end else if (at_end) begin
                m_sd = '0; unr_set = 1;
            end
        end
        m_unr = unr_set || (m_unr && !clr);
        m_ovf = ovf_set || (m_ovf && !clr);
`ifdef SD2_CTRL_OVLD_EN
        m_ovld = ovl_set || (m_ovld && !clr);
`endif
    endfunction

    function automatic void check_outs();
        chk("sd_out",    sd_out,    m_sd);
        chk("out_valid", out_valid, m_ov);
        chk("out_data",  out_data,  m_od);
        chk("underrun",  underrun,  m_unr);
        chk("overflow",  overflow,  m_ovf);
        chk("ovld",      ovld,      m_ovld);
    endfunction

    task automatic step();
        #1;
        chk("in_ready", in_ready, m_rdy());
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
        check_outs();
    endtask

    task automatic send_byte(input logic [7:0] w);
        for (int k = 7; k >= 0; k--) begin
            bs_in = w[k];
            step();
        end
    endtask

    typedef struct {
        logic          vld;
        logic [BW-1:0] data;
        logic          bs;
        logic          clr;
        logic          e_rdy;
        logic [BW-1:0] e_sd;
        logic          e_ov;
        logic [WW-1:0] e_od;
        logic          e_unr;
    } vec_t;

    function automatic vec_t mk(input logic v, input int d, input logic b, input logic c,
                                input logic r, input int s, input logic ov,
                                input logic [WW-1:0] od, input logic u);
        vec_t t;
        t.vld = v; t.data = BW'(d); t.bs = b; t.clr = c; t.e_rdy = r;
        t.e_sd = BW'(s); t.e_ov = ov; t.e_od = od; t.e_unr = u;
        return t;
    endfunction

    vec_t tbl[14];
    logic [7:0] w3;

    initial begin
        // Back-to-back 100/-100, bits 1,0,1,1,0,0,1,0 -> 8'hB2, then starvation and recovery.
        tbl[0]  = mk(1,  100, 0, 0, 1,  100, 0, 8'h00, 0);
        tbl[1]  = mk(1, -100, 1, 0, 0,  100, 0, 8'h00, 0);
        tbl[2]  = mk(1, -100, 0, 0, 0,  100, 0, 8'h00, 0);
        tbl[3]  = mk(1, -100, 1, 0, 0,  100, 0, 8'h00, 0);
        tbl[4]  = mk(1, -100, 1, 0, 1, -100, 0, 8'h00, 0);
        tbl[5]  = mk(0,    0, 0, 0, 0, -100, 0, 8'h00, 0);
        tbl[6]  = mk(0,    0, 0, 0, 0, -100, 0, 8'h00, 0);
        tbl[7]  = mk(0,    0, 1, 0, 0, -100, 0, 8'h00, 0);
        tbl[8]  = mk(0,    0, 0, 0, 1,    0, 1, 8'hB2, 1);
        tbl[9]  = mk(0,    0, 0, 0, 0,    0, 0, 8'hB2, 1);
        tbl[10] = mk(1,   55, 0, 0, 0,    0, 0, 8'hB2, 1);
        tbl[11] = mk(1,   55, 0, 0, 0,    0, 0, 8'hB2, 1);
        tbl[12] = mk(1,   55, 0, 0, 1,   55, 0, 8'hB2, 1);
        tbl[13] = mk(0,    0, 0, 1, 0,   55, 0, 8'hB2, 0);

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outs();
        chk("reset in_ready", in_ready, 1'b0);
        rst_n = 1'b1;

        en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            in_valid = tbl[i].vld; in_data = tbl[i].data;
            bs_in = tbl[i].bs; clr = tbl[i].clr;
            #1;
            chk("tbl in_ready", in_ready, tbl[i].e_rdy);
            step();
            chk("tbl sd_out",    sd_out,    tbl[i].e_sd);
            chk("tbl out_valid", out_valid, tbl[i].e_ov);
            chk("tbl out_data",  out_data,  tbl[i].e_od);
            chk("tbl underrun",  underrun,  tbl[i].e_unr);
        end
        clr = 1'b0;

        // Overflow: two words with no reader, then handshake on the completing edge.
        en = 1'b0; step();
        en = 1'b1; in_valid = 1'b1; in_data = BW'(7); out_ready = 1'b0; step();
        send_byte(8'hA5);
        chk("ovf w1 valid", out_valid, 1'b1);
        chk("ovf w1 data",  out_data,  8'hA5);
        chk("ovf not yet",  overflow,  1'b0);
        send_byte(8'h3C);
        chk("ovf set",      overflow,  1'b1);
        chk("ovf w1 held",  out_data,  8'hA5);
        w3 = 8'h96;
        for (int k = 7; k >= 0; k--) begin
            bs_in = w3[k]; clr = (k == 7); out_ready = (k == 0);
            step();
        end
        clr = 1'b0;
        chk("hs+done valid",    out_valid, 1'b1);
        chk("hs+done data",     out_data,  8'h96);
        chk("hs+done overflow", overflow,  1'b0);
        out_ready = 1'b1; step();
        chk("hs drained", out_valid, 1'b0);

        // Asynchronous reset in the middle of a frame.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst sd_out",    sd_out,    '0);
        chk("arst in_ready",  in_ready,  1'b0);
        chk("arst out_valid", out_valid, 1'b0);
        chk("arst out_data",  out_data,  '0);
        chk("arst underrun",  underrun,  1'b0);
        chk("arst overflow",  overflow,  1'b0);
        chk("arst ovld",      ovld,      1'b0);
        model_reset();
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("idle in_ready", in_ready, 1'b1);
        chk("idle sd_out",   sd_out,   '0);

        // Overload run length: 23 ones then a zero, then 24 ones.
        en = 1'b0; step();
        en = 1'b1; in_valid = 1'b1; in_data = BW'(3); step();
        bs_in = 1'b1; repeat (23) step();
        bs_in = 1'b0; step();
        chk("ovld 23+0", ovld, 1'b0);
        bs_in = 1'b1; repeat (23) step();
        chk("ovld 23", ovld, 1'b0);
        step();
        chk("ovld 24", ovld, c_OVL_EXP);
        clr = 1'b1; bs_in = 1'b0; step();
        clr = 1'b0;
        chk("ovld clr", ovld, 1'b0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            en        = ($urandom_range(0, 31) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = BW'(int'($urandom_range(0, 32768)) - 16384);
            if ($urandom_range(0, 15) == 0) bs_in = ~bs_in;
            out_ready = ($urandom_range(0, 3) != 0);
            clr       = ($urandom_range(0, 31) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
